// File: rtl/dram_responder.sv
// Single-bank DRAM responder: ACT/PRE/RD/WR command decode, tRCD check,
// byte-masked word storage and a fixed-latency read-return pipeline.
module dram_responder #(
  parameter int unsigned CL           = 5,
  parameter int unsigned TRCD         = 5,
  parameter int unsigned MEM_ROW_BITS = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        CSn,
  input  logic        RASn,
  input  logic        CASn,
  input  logic [3:0]  WEn,
  input  logic [10:0] A,
  input  logic [31:0] D,
  output logic [31:0] Q,
  output logic        VALID,
  output logic        ERR
);

  localparam int unsigned ADDR_W = MEM_ROW_BITS + 10;
  localparam int unsigned DEPTH  = 1 << ADDR_W;
  localparam int unsigned CNT_W  = $clog2(TRCD + 1);

  if (CL < 1 || TRCD < 1) begin : g_param_check
    $error("dram_responder: CL and TRCD must both be at least 1");
  end

  typedef enum logic {CLOSED = 1'b0, OPEN = 1'b1} state_t;

  state_t             state;
  logic [10:0]        row;
  logic [CNT_W-1:0]   cnt;
  logic [31:0]        mem [DEPTH];
  logic [CL-1:0]      pv;
  logic [31:0]        pd [CL];

  logic               cmd_en, we_none;
  logic               is_act, is_pre, is_rd, is_wr, is_bad;
  logic               trcd_met, rd_ok, wr_ok;
  logic [ADDR_W-1:0]  addr;
  logic [31:0]        rdata;
  logic               unused_row_bits;

  // Command decode; nothing is decoded on reset edges.
  assign cmd_en  = !rst && !CSn;
  assign we_none = (WEn == 4'hF);
  assign is_act  = cmd_en && !RASn &&  CASn &&  we_none;
  assign is_pre  = cmd_en && !RASn &&  CASn && !we_none;
  assign is_rd   = cmd_en &&  RASn && !CASn &&  we_none;
  assign is_wr   = cmd_en &&  RASn && !CASn && !we_none;
  assign is_bad  = cmd_en && !RASn && !CASn;

  // cnt holds edges since ACT minus one, so cnt+1 >= TRCD means the window is met.
  assign trcd_met = (cnt >= CNT_W'(TRCD - 1));
  assign rd_ok    = is_rd && (state == OPEN) && trcd_met;
  assign wr_ok    = is_wr && (state == OPEN) && trcd_met;

  assign addr            = {row[MEM_ROW_BITS-1:0], A[9:0]};
  assign rdata           = mem[addr];
  assign unused_row_bits = ^row[10:MEM_ROW_BITS];

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (wr_ok && !WEn[i]) mem[addr][8*i +: 8] <= D[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLOSED;
      row   <= '0;
      cnt   <= '0;
      ERR   <= 1'b0;
      pv    <= '0;
      for (int i = 0; i < int'(CL); i++) pd[i] <= '0;
    end else begin
      ERR <= is_bad;
      unique case (state)
        CLOSED: begin
          if (is_act) begin
            row   <= A;
            cnt   <= '0;
            state <= OPEN;
          end else if (is_pre || is_rd || is_wr) begin
            ERR <= 1'b1;
          end
        end
        OPEN: begin
          if (cnt != CNT_W'(TRCD)) cnt <= cnt + CNT_W'(1);
          if (is_pre) state <= CLOSED;
          else if (is_act || ((is_rd || is_wr) && !trcd_met)) ERR <= 1'b1;
        end
      endcase
      // Read return pipe; data stages only move with a valid token so Q holds.
      pv[0] <= rd_ok;
      if (rd_ok) pd[0] <= rdata;
      for (int i = 1; i < int'(CL); i++) begin
        pv[i] <= pv[i-1];
        if (pv[i-1]) pd[i] <= pd[i-1];
      end
    end
  end

  assign VALID = pv[CL-1];
  assign Q     = pd[CL-1];

endmodule

// File: tb/tb_dram_responder.sv
// Scoreboard bench for dram_responder: directed scenarios then randomized
// commands against a cycle-stamped behavioural model.
module tb_dram_responder;

  localparam int CL   = 5;
  localparam int TRCD = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        CSn = 1'b1, RASn = 1'b1, CASn = 1'b1;
  logic [3:0]  WEn = 4'hF;
  logic [10:0] A = '0;
  logic [31:0] D = '0;
  logic [31:0] Q;
  logic        VALID, ERR;

  dram_responder #(.CL(CL), .TRCD(TRCD), .MEM_ROW_BITS(2)) dut (
    .clk(clk), .rst(rst), .CSn(CSn), .RASn(RASn), .CASn(CASn),
    .WEn(WEn), .A(A), .D(D), .Q(Q), .VALID(VALID), .ERR(ERR)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct { int due; logic [31:0] data; } exp_t;
  exp_t        sb[$];
  bit          err_exp[int];
  int          n_cmp = 0, n_bad = 0;
  logic [31:0] last_q = '0;

  // Reference model: bank open flag, edge number of the last ACT, row, memory.
  bit          m_open = 1'b0;
  int          m_act  = 0;
  int          m_row  = 0;
  logic [31:0] mmem[int];

  task automatic chk(input bit ok, input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, got, want);
    end
  endtask

  // Monitor: outputs seen here were produced by posedge number cyc.
  always @(negedge clk) begin
    if (rst) begin
      chk(!VALID && !ERR && Q == 32'h0, "reset_outputs", {VALID, ERR, Q[29:0]}, 32'h0);
      last_q = '0;
    end else begin
      chk(ERR == err_exp.exists(cyc), "err", 32'(ERR), 32'(err_exp.exists(cyc)));
      if (VALID) begin
        if (sb.size() == 0 || sb[0].due != cyc) begin
          chk(1'b0, "unexpected_valid", Q, (sb.size() == 0) ? 32'hFFFF_FFFF : 32'(sb[0].due));
        end else begin
          chk(Q == sb[0].data, "read_data", Q, sb[0].data);
          last_q = sb[0].data;
          void'(sb.pop_front());
        end
      end else begin
        if (sb.size() != 0 && sb[0].due <= cyc) begin
          chk(1'b0, "missing_valid", 32'(cyc), 32'(sb[0].due));
          void'(sb.pop_front());
        end
        chk(Q == last_q, "q_hold", Q, last_q);
      end
    end
  end

  // Drive one edge worth of inputs and advance the model to that edge.
  task automatic issue(input bit csn, input bit rasn, input bit casn, input logic [3:0] wen,
                       input logic [10:0] a, input logic [31:0] d, input bit r);
    int e, addr;
    logic [31:0] w;
    @(negedge clk);
    #2;
    rst = r; CSn = csn; RASn = rasn; CASn = casn; WEn = wen; A = a; D = d;
    e = cyc + 1;
    if (r) begin
      m_open = 1'b0;
      sb.delete();
    end else if (!csn) begin
      if (!rasn && !casn) err_exp[e] = 1'b1;
      else if (!rasn && wen == 4'hF) begin
        if (m_open) err_exp[e] = 1'b1;
        else begin m_open = 1'b1; m_act = e; m_row = int'(a); end
      end else if (!rasn) begin
        if (!m_open) err_exp[e] = 1'b1;
        else m_open = 1'b0;
      end else if (!casn) begin
        if (!m_open || (e - m_act) < TRCD) err_exp[e] = 1'b1;
        else begin
          addr = (m_row % 4) * 1024 + (int'(a) % 1024);
          if (wen == 4'hF) sb.push_back('{due: e + CL - 1, data: mmem[addr]});
          else begin
            w = mmem.exists(addr) ? mmem[addr] : 32'h0;
            for (int i = 0; i < 4; i++) if (!wen[i]) w[8*i +: 8] = d[8*i +: 8];
            mmem[addr] = w;
          end
        end
      end
    end
  endtask

  task automatic nop(input int n);
    for (int i = 0; i < n; i++) issue(1'b1, 1'b1, 1'b1, 4'hF, '0, '0, 1'b0);
  endtask
  task automatic act(input logic [10:0] a);  issue(1'b0, 1'b0, 1'b1, 4'hF, a, '0, 1'b0); endtask
  task automatic pre();                      issue(1'b0, 1'b0, 1'b1, 4'h0, 11'h7FF, '0, 1'b0); endtask
  task automatic rd(input logic [10:0] a);   issue(1'b0, 1'b1, 1'b0, 4'hF, a, '0, 1'b0); endtask
  task automatic wr(input logic [10:0] a, input logic [31:0] d, input logic [3:0] wen);
    issue(1'b0, 1'b1, 1'b0, wen, a, d, 1'b0);
  endtask
  task automatic bad();                      issue(1'b0, 1'b0, 1'b0, 4'hF, '0, '0, 1'b0); endtask
  task automatic reset(input int n);
    for (int i = 0; i < n; i++) issue(1'b1, 1'b1, 1'b1, 4'hF, '0, '0, 1'b1);
  endtask

  initial begin
    int r;
    logic [3:0] wen;
    reset(3);

    // Full write then reopen and read back.
    act(11'd3); nop(4); wr(11'h010, 32'hA5A5_1234, 4'h0); pre();
    act(11'd3); nop(4); rd(11'h010); nop(CL + 1);
    // Upper-half byte mask keeps the top bytes.
    wr(11'h010, 32'h0000_BEEF, 4'b1100); rd(11'h010); nop(CL + 1);
    pre();

    // tRCD window: early RD rejected, RD at ACT+5 accepted.
    act(11'd3); nop(2); rd(11'h010); nop(1); rd(11'h010); nop(CL + 1);

    // Back-to-back reads, then RD followed by WR to the same word before VALID.
    wr(11'h000, 32'h1111_0000, 4'h0); wr(11'h001, 32'h2222_0001, 4'h0); wr(11'h002, 32'h3333_0002, 4'h0);
    rd(11'h000); rd(11'h001); rd(11'h002); nop(CL + 1);
    rd(11'h001); wr(11'h001, 32'hDEAD_BEEF, 4'h0); nop(CL + 1);
    // In-flight reads survive a following PRE and ACT.
    rd(11'h002); pre(); act(11'h403); nop(CL + 1);

    // Protocol errors: illegal encoding while OPEN keeps the bank open.
    bad(); nop(TRCD); rd(11'h001); nop(CL + 1); pre();
    pre(); act(11'd3); act(11'd2); rd(11'h000); wr(11'h000, 32'h0, 4'h0);

    // Read flushed by reset; storage survives.
    nop(TRCD); rd(11'h000); nop(1); reset(1); nop(8);
    act(11'h7F7); nop(4); rd(11'h010); nop(CL + 1); pre();

    // Seed columns 0..7 of every backed row, then randomized traffic.
    for (int row = 0; row < 4; row++) begin
      act(11'(row)); nop(TRCD - 1);
      for (int c = 0; c < 8; c++) wr(11'(c), $urandom, 4'h0);
      pre();
    end
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 99);
      wen = 4'($urandom_range(0, 14));
      if (r < 8)       act(11'($urandom));
      else if (r < 15) pre();
      else if (r < 45) rd(11'($urandom_range(0, 7)));
      else if (r < 65) wr(11'($urandom_range(0, 7)), $urandom, wen);
      else if (r < 68) bad();
      else if (r < 72) issue(1'b1, 1'($urandom), 1'($urandom), 4'($urandom), 11'($urandom), $urandom, 1'b0);
      else if (r < 73) reset(1);
      else             nop(1);
    end
    nop(CL + 2);
    chk(sb.size() == 0, "scoreboard_drained", 32'(sb.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
